dma_bus_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single bus master port between NR_OF_MASTERS DMA-style

---
 rtl/dma_bus_pkg.sv | 13 +
 rtl/dma_bus_arbiter_rr_priority_picker.sv | 25 ++
 rtl/dma_bus_arbiter.sv | 76 +++++++
 tb/tb_dma_bus_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_bus_pkg.sv
// dma_bus_pkg: shared FSM encoding and sizing for the DMA bus arbiter
// Contents: state_t (IDLE=0, GRANT=1, WAIT_BEGIN=2, ACTIVE=3, RELEASE=4), MAX_MASTERS, IDX_W
package dma_bus_pkg;
    localparam int MAX_MASTERS = 8;
    localparam int IDX_W = $clog2(MAX_MASTERS);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GRANT      = 3'd1,
        WAIT_BEGIN = 3'd2,
        ACTIVE     = 3'd3,
        RELEASE    = 3'd4
    } state_t;
endpackage

// File: rtl/dma_bus_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first request at or after a pointer
// Ports: i_req  in  N      request vector, bit i = master i
//        i_ptr  in  IDX_W  highest-priority index this round (must be < N)
//        o_valid out 1     any request present
//        o_idx  out IDX_W  winning master index
module rr_priority_picker
    import dma_bus_pkg::*;
#(
    parameter int N = 4
)(
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);
    logic [N-1:0] w_rot;
    // rotate so bit 0 is the pointer position; the lowest set bit then wins
    assign w_rot = N'({i_req, i_req} >> i_ptr);
    assign o_valid = |i_req;
    always_comb begin
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (w_rot[k]) o_idx = IDX_W'((int'(i_ptr) + k) % N);
    end
endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: round-robin owner of the shared bus master port for DMA custom instructions
// Ports: clock/reset (sync, active-low); requestIn[N] in; grantOut[N] out (one-hot 1-cycle pulse);
//        beginTransactionIn/endTransactionIn/busErrorIn in (shared bus observation);
//        busBusy, activeMaster[3], endTransactionOut, busErrorOut out
// Build option: DMA_BUS_ARBITER_WATCHDOG_EN enables the transaction-length watchdog;
//        otherwise endTransactionOut/busErrorOut are 0 and ACTIVE waits indefinitely.
module dma_bus_arbiter
    import dma_bus_pkg::*;
#(
    parameter int NR_OF_MASTERS   = 4,
    parameter int BEGIN_TIMEOUT   = 15,
    parameter int WATCHDOG_CYCLES = 1023
)(
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NR_OF_MASTERS-1:0] requestIn,
    output logic [NR_OF_MASTERS-1:0] grantOut,
    input  logic                     beginTransactionIn,
    input  logic                     endTransactionIn,
    input  logic                     busErrorIn,
    output logic                     busBusy,
    output logic [2:0]               activeMaster,
    output logic                     endTransactionOut,
    output logic                     busErrorOut
);
    localparam int CNT_W = $clog2(((BEGIN_TIMEOUT > WATCHDOG_CYCLES) ? BEGIN_TIMEOUT : WATCHDOG_CYCLES) + 1);
    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_ptr, r_active, w_pick;
    logic             w_valid, w_wd_fire;
    logic [CNT_W-1:0] r_cnt;
    rr_priority_picker #(.N(NR_OF_MASTERS)) u_picker (
        .i_req  (requestIn),
        .i_ptr  (r_ptr),
        .o_valid(w_valid),
        .o_idx  (w_pick)
    );
`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
    // a real end or error in the limit cycle takes precedence over the forced pulse
    assign w_wd_fire = r_state == ACTIVE && r_cnt == CNT_W'(WATCHDOG_CYCLES)
                       && !endTransactionIn && !busErrorIn;
`else
    assign w_wd_fire = 1'b0;
`endif
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       w_next = w_valid ? GRANT : IDLE;
            GRANT:      w_next = WAIT_BEGIN;
            WAIT_BEGIN: w_next = beginTransactionIn ? ACTIVE :
                                 (r_cnt == CNT_W'(BEGIN_TIMEOUT)) ? RELEASE : WAIT_BEGIN;
            ACTIVE:     w_next = (endTransactionIn || busErrorIn || w_wd_fire) ? RELEASE : ACTIVE;
            default:    w_next = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_active <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_valid) r_active <= w_pick;
            if (r_state == RELEASE)
                r_ptr <= (r_active == IDX_W'(NR_OF_MASTERS - 1)) ? '0 : r_active + 1'b1;
            // one counter serves both the begin timeout and the watchdog; restart on entry, saturate
            r_cnt <= (w_next != r_state && (w_next == WAIT_BEGIN || w_next == ACTIVE)) ? '0 :
                     r_cnt + CNT_W'(r_cnt != '1);
        end
    end
    assign grantOut          = (r_state == GRANT) ? NR_OF_MASTERS'(1) << r_active : '0;
    assign busBusy           = r_state == GRANT || r_state == WAIT_BEGIN || r_state == ACTIVE;
    assign activeMaster      = r_active;
    assign endTransactionOut = w_wd_fire;
    assign busErrorOut       = w_wd_fire;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: directed self-checking bench for dma_bus_arbiter (N=4, timeout 15, watchdog 20)
module tb_dma_bus_arbiter;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] requestIn = '0;
    logic [3:0] grantOut;
    logic       beginTransactionIn = 1'b0;
    logic       endTransactionIn = 1'b0;
    logic       busErrorIn = 1'b0;
    logic       busBusy;
    logic [2:0] activeMaster;
    logic       endTransactionOut;
    logic       busErrorOut;
    int checks = 0;
    int fails = 0;

    dma_bus_arbiter #(.NR_OF_MASTERS(4), .BEGIN_TIMEOUT(15), .WATCHDOG_CYCLES(20)) dut (
        .clock(clock), .reset(reset), .requestIn(requestIn), .grantOut(grantOut),
        .beginTransactionIn(beginTransactionIn), .endTransactionIn(endTransactionIn),
        .busErrorIn(busErrorIn), .busBusy(busBusy), .activeMaster(activeMaster),
        .endTransactionOut(endTransactionOut), .busErrorOut(busErrorOut)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_grant(output logic [3:0] g);
        int n = 0;
        while (grantOut == 4'b0000 && n < 8) begin
            tick(1);
            n++;
        end
        g = grantOut;
    endtask

    task automatic run_txn();
        tick(1);
        beginTransactionIn = 1'b1;
        tick(1);
        beginTransactionIn = 1'b0;
        endTransactionIn = 1'b1;
        tick(1);
        endTransactionIn = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        checks++;
        if ({grantOut, busBusy, activeMaster, endTransactionOut, busErrorOut} !== 10'b0) begin
            fails++;
            $display("FAIL reset_outputs got g=%b busy=%b am=%0d eo=%b be=%b required all 0",
                     grantOut, busBusy, activeMaster, endTransactionOut, busErrorOut);
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        requestIn = 4'b0100;
        tick(1);
        checks++;
        if ({grantOut, busBusy, activeMaster} !== {4'b0100, 1'b1, 3'd2}) begin
            fails++;
            $display("FAIL single_grant got g=%b busy=%b am=%0d required 0100/1/2",
                     grantOut, busBusy, activeMaster);
        end
        requestIn = 4'b0000;
        tick(1);
        checks++;
        if ({grantOut, busBusy} !== {4'b0000, 1'b1}) begin
            fails++;
            $display("FAIL single_pulse got g=%b busy=%b required 0000/1", grantOut, busBusy);
        end
        beginTransactionIn = 1'b1;
        tick(1);
        beginTransactionIn = 1'b0;
        tick(4);
        checks++;
        if (busBusy !== 1'b1) begin
            fails++;
            $display("FAIL single_active_busy got %b required 1", busBusy);
        end
        endTransactionIn = 1'b1;
        tick(1);
        endTransactionIn = 1'b0;
        checks++;
        if (busBusy !== 1'b0) begin
            fails++;
            $display("FAIL single_release_busy got %b required 0", busBusy);
        end
        tick(1);
        checks++;
        if ({grantOut, busBusy} !== 5'b0) begin
            fails++;
            $display("FAIL single_idle got g=%b busy=%b required 0000/0", grantOut, busBusy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] g;
        do_reset();
        requestIn = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g);
            checks++;
            if (g !== exp_g[i] || activeMaster !== 3'(i % 4)) begin
                fails++;
                $display("FAIL rr_grant_%0d got g=%b am=%0d required g=%b am=%0d",
                         i, g, activeMaster, exp_g[i], i % 4);
            end
            run_txn();
        end
        requestIn = 4'b0000;
        tick(2);
    endtask

    task automatic test_begin_timeout();
        logic [3:0] g;
        int n = 0;
        do_reset();
        requestIn = 4'b0010;
        wait_grant(g);
        checks++;
        if (g !== 4'b0010) begin
            fails++;
            $display("FAIL timeout_grant1 got %b required 0010", g);
        end
        requestIn = 4'b1000;
        while (busBusy === 1'b1 && n < 40) begin
            tick(1);
            n++;
            if (n == 8) begin
                checks++;
                if (grantOut !== 4'b0000) begin
                    fails++;
                    $display("FAIL timeout_no_grant_while_waiting got %b required 0000", grantOut);
                end
            end
        end
        checks++;
        if (n !== 17) begin
            fails++;
            $display("FAIL timeout_busy_cycles got %0d required 17", n);
        end
        wait_grant(g);
        checks++;
        if (g !== 4'b1000 || activeMaster !== 3'd3) begin
            fails++;
            $display("FAIL timeout_next_grant got g=%b am=%0d required 1000/3", g, activeMaster);
        end
        requestIn = 4'b0000;
    endtask

    task automatic test_reset_active();
        logic [3:0] g;
        tick(1);
        beginTransactionIn = 1'b1;
        tick(1);
        beginTransactionIn = 1'b0;
        checks++;
        if (busBusy !== 1'b1) begin
            fails++;
            $display("FAIL rst_active_busy got %b required 1", busBusy);
        end
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        checks++;
        if ({grantOut, busBusy, activeMaster} !== 8'b0) begin
            fails++;
            $display("FAIL rst_active_cleared got g=%b busy=%b am=%0d required 0", grantOut, busBusy, activeMaster);
        end
        requestIn = 4'b0110;
        wait_grant(g);
        checks++;
        if (g !== 4'b0010) begin
            fails++;
            $display("FAIL rst_active_pointer got %b required 0010", g);
        end
        requestIn = 4'b0000;
    endtask

    task automatic test_end_error();
        logic [3:0] g;
        tick(1);
        beginTransactionIn = 1'b1;
        tick(1);
        beginTransactionIn = 1'b0;
        endTransactionIn = 1'b1;
        busErrorIn = 1'b1;
        tick(1);
        endTransactionIn = 1'b0;
        busErrorIn = 1'b0;
        checks++;
        if ({grantOut, busBusy} !== 5'b0) begin
            fails++;
            $display("FAIL end_err_release got g=%b busy=%b required 0000/0", grantOut, busBusy);
        end
        tick(2);
        checks++;
        if ({grantOut, busBusy} !== 5'b0) begin
            fails++;
            $display("FAIL end_err_no_regrant got g=%b busy=%b required 0000/0", grantOut, busBusy);
        end
        beginTransactionIn = 1'b1;
        endTransactionIn = 1'b1;
        tick(1);
        beginTransactionIn = 1'b0;
        endTransactionIn = 1'b0;
        tick(1);
        checks++;
        if ({grantOut, busBusy} !== 5'b0) begin
            fails++;
            $display("FAIL idle_ignores_pulses got g=%b busy=%b required 0000/0", grantOut, busBusy);
        end
        requestIn = 4'b0100;
        wait_grant(g);
        requestIn = 4'b0000;
        tick(1);
        endTransactionIn = 1'b1;
        tick(1);
        endTransactionIn = 1'b0;
        tick(1);
        checks++;
        if (busBusy !== 1'b1) begin
            fails++;
            $display("FAIL wait_ignores_end got busy=%b required 1", busBusy);
        end
        run_txn();
        tick(1);
    endtask

    task automatic test_watchdog();
        logic [3:0] g;
        requestIn = 4'b0001;
        wait_grant(g);
        requestIn = 4'b0000;
        tick(1);
        beginTransactionIn = 1'b1;
        tick(1);
        beginTransactionIn = 1'b0;
`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
        tick(19);
        checks++;
        if ({endTransactionOut, busErrorOut, busBusy} !== 3'b001) begin
            fails++;
            $display("FAIL wd_early got eo=%b be=%b busy=%b required 0/0/1", endTransactionOut, busErrorOut, busBusy);
        end
        tick(1);
        checks++;
        if ({endTransactionOut, busErrorOut, busBusy} !== 3'b111) begin
            fails++;
            $display("FAIL wd_fire got eo=%b be=%b busy=%b required 1/1/1", endTransactionOut, busErrorOut, busBusy);
        end
        tick(1);
        checks++;
        if ({endTransactionOut, busErrorOut, busBusy} !== 3'b000) begin
            fails++;
            $display("FAIL wd_release got eo=%b be=%b busy=%b required 0/0/0", endTransactionOut, busErrorOut, busBusy);
        end
`else
        tick(25);
        checks++;
        if ({endTransactionOut, busErrorOut, busBusy} !== 3'b001) begin
            fails++;
            $display("FAIL no_wd_holds got eo=%b be=%b busy=%b required 0/0/1", endTransactionOut, busErrorOut, busBusy);
        end
        endTransactionIn = 1'b1;
        tick(1);
        endTransactionIn = 1'b0;
        checks++;
        if (busBusy !== 1'b0) begin
            fails++;
            $display("FAIL no_wd_release got busy=%b required 0", busBusy);
        end
`endif
        tick(2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_begin_timeout();
        test_reset_active();
        test_end_error();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
